// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode constants, type encodings and decode helpers
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } insn_type_e;

  // What the IF/ID register does on the next edge; idle shares the bubble action
  typedef enum logic [1:0] {
    ACT_FLUSH   = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_CAPTURE = 2'd3
  } stage_act_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Jumps and LUI carry no rs operand
  function automatic logic reads_rs(input logic [5:0] op);
    return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
  endfunction

  // rt is an operand for R-type ALU ops, compare branches and stores
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic zero_ext_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard check between held and incoming instruction
module load_use_detect
  import mips_defs::*;
(
  input  logic [31:0] held_ir_i,
  input  logic        held_valid_i,
  input  logic [31:0] insn_i,
  input  logic        insn_valid_i,
  output logic        hazard_o
);

  logic [5:0] held_op;
  logic [4:0] load_rt;
  logic [5:0] in_op;
  logic [4:0] in_rs;
  logic [4:0] in_rt;
  logic       held_is_load;
  logic       rs_hit;
  logic       rt_hit;
  logic       unused_bits;

  assign held_op = held_ir_i[31:26];
  assign load_rt = held_ir_i[20:16];
  assign in_op   = insn_i[31:26];
  assign in_rs   = insn_i[25:21];
  assign in_rt   = insn_i[20:16];

  // Immediate/rd bits never participate in the dependency check
  assign unused_bits = ^{held_ir_i[25:21], held_ir_i[15:0], insn_i[15:0]};

  // A load into $0 produces nothing, so it can never be a hazard source
  always_comb begin
    held_is_load = held_valid_i && is_load(held_op);
    rs_hit       = reads_rs(in_op) && (in_rs == load_rt);
    rt_hit       = reads_rt(in_op) && (in_rt == load_rt);
    hazard_o     = held_is_load && (load_rt != 5'd0) && insn_valid_i && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/decode.sv
// rtl/decode.sv - PD3 decode stage: IF/ID register, stall/flush/bubble priority and field decode
module decode #(
  parameter logic [31:0] start_addr = 32'h8002_0000,
  parameter logic [31:0] NOP_WORD   = mips_defs::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] insn,
  input  logic [31:0] insn_pc,
  input  logic        insn_valid,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] insn_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_ext,
  output logic [25:0] target,
  output logic [1:0]  insn_type
);

  import mips_defs::*;

  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        hazard;
  stage_act_e  act;
  insn_type_e  type_dec;

  load_use_detect u_load_use_detect (
    .held_ir_i    (ir_q),
    .held_valid_i (valid_q),
    .insn_i       (insn),
    .insn_valid_i (insn_valid),
    .hazard_o     (hazard)
  );

  // Fetch holds whenever this stage will not take the incoming word, except on flush
  assign stall_out = !flush && (stall_in || hazard);

  // Pick the stage action by priority, then form the next register contents
  always_comb begin
    act     = ACT_BUBBLE;
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (stall_in) begin
      act = ACT_HOLD;
    end else if (hazard) begin
      act = ACT_BUBBLE;
    end else if (insn_valid) begin
      act = ACT_CAPTURE;
    end
    case (act)
      ACT_HOLD: begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        valid_d = valid_q;
      end
      ACT_CAPTURE: begin
        ir_d    = insn;
        pc_d    = insn_pc;
        valid_d = 1'b1;
      end
      default: begin
        ir_d    = NOP_WORD;
        pc_d    = pc_q;
        valid_d = 1'b0;
      end
    endcase
  end

  // IF/ID pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= NOP_WORD;
      pc_q    <= start_addr;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign insn_out  = ir_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign target = ir_q[25:0];

  // Logical immediates zero-extend; everything else sign-extends
  always_comb begin
    imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    if (zero_ext_imm(ir_q[31:26])) begin
      imm_ext = {16'h0000, ir_q[15:0]};
    end
  end

  // Classify by opcode: 0 is R, jumps are J, the rest I
  always_comb begin
    type_dec = TYPE_I;
    if (ir_q[31:26] == OP_RTYPE) begin
      type_dec = TYPE_R;
    end else if ((ir_q[31:26] == OP_J) || (ir_q[31:26] == OP_JAL)) begin
      type_dec = TYPE_J;
    end
  end

  assign insn_type = type_dec;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - table-driven and sequence checks for the decode stage
module tb_decode;

  logic        clock;
  logic        reset_n;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        stall_in;
  logic        flush;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] insn_out;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [25:0] target;
  logic [1:0]  insn_type;

  int total;
  int bad;

  decode dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_valid (insn_valid),
    .stall_in   (stall_in),
    .flush      (flush),
    .stall_out  (stall_out),
    .valid_out  (valid_out),
    .pc_out     (pc_out),
    .insn_out   (insn_out),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm_ext    (imm_ext),
    .target     (target),
    .insn_type  (insn_type)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [1:0]  ty;
    logic [25:0] tgt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] pc, input logic v);
    insn       = w;
    insn_pc    = pc;
    insn_valid = v;
  endtask

  // Capture one non-hazard word and leave it held
  task automatic load_word(input logic [31:0] w, input logic [31:0] pc);
    drive(w, pc, 1'b1);
    #1;
    tick();
  endtask

  logic [31:0] snap_insn;
  logic [31:0] snap_pc;

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    drive(32'h0, 32'h0, 1'b0);

    //           word          op     rs     rt     rd     sh     fn     imm            ty    tgt
    vecs[0] = '{32'h00221820, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 32'h00001820, 2'd0, 26'h0221820};
    vecs[1] = '{32'h2001FFFF, 6'h08, 5'd0,  5'd1,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 2'd1, 26'h001FFFF};
    vecs[2] = '{32'h3421FFFF, 6'h0D, 5'd1,  5'd1,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 2'd1, 26'h021FFFF};
    vecs[3] = '{32'h0C000010, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 32'h00000010, 2'd2, 26'h0000010};
    vecs[4] = '{32'h30428000, 6'h0C, 5'd2,  5'd2,  5'd16, 5'd0,  6'h00, 32'h00008000, 2'd1, 26'h0428000};
    vecs[5] = '{32'h38A58000, 6'h0E, 5'd5,  5'd5,  5'd16, 5'd0,  6'h00, 32'h00008000, 2'd1, 26'h0A58000};
    vecs[6] = '{32'h28218000, 6'h0A, 5'd1,  5'd1,  5'd16, 5'd0,  6'h00, 32'hFFFF8000, 2'd1, 26'h0218000};
    vecs[7] = '{32'h08000004, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h04, 32'h00000004, 2'd2, 26'h0000004};
    vecs[8] = '{32'h00021100, 6'h00, 5'd0,  5'd2,  5'd2,  5'd4,  6'h00, 32'h00001100, 2'd0, 26'h0021100};

    // Reset state
    #12;
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_pc", pc_out, 32'h80020000);
    chk("rst_insn", insn_out, 32'h0);
    chk("rst_imm", imm_ext, 32'h0);
    chk("rst_type", {30'b0, insn_type}, 32'h0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    chk("rst_stall", {31'b0, stall_out}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table: capture each word and check its decode on the following cycle
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].word, 32'h80020000 + 32'(i * 4), 1'b1);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, valid_out}, 32'h1);
      chk($sformatf("v%0d_pc", i), pc_out, 32'h80020000 + 32'(i * 4));
      chk($sformatf("v%0d_insn", i), insn_out, vecs[i].word);
      chk($sformatf("v%0d_op", i), {26'b0, opcode}, {26'b0, vecs[i].op});
      chk($sformatf("v%0d_rs", i), {27'b0, rs}, {27'b0, vecs[i].rs});
      chk($sformatf("v%0d_rt", i), {27'b0, rt}, {27'b0, vecs[i].rt});
      chk($sformatf("v%0d_rd", i), {27'b0, rd}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_sh", i), {27'b0, shamt}, {27'b0, vecs[i].sh});
      chk($sformatf("v%0d_fn", i), {26'b0, funct}, {26'b0, vecs[i].fn});
      chk($sformatf("v%0d_imm", i), imm_ext, vecs[i].imm);
      chk($sformatf("v%0d_type", i), {30'b0, insn_type}, {30'b0, vecs[i].ty});
      chk($sformatf("v%0d_tgt", i), {6'b0, target}, {6'b0, vecs[i].tgt});
      chk($sformatf("v%0d_stall", i), {31'b0, stall_out}, 32'h0);
    end

    // Load-use: lw $2 then add $3,$2,$4 -> one bubble, add captured on re-presentation
    load_word(32'h8C220000, 32'h80020100);
    drive(32'h00441820, 32'h80020104, 1'b1);
    #1;
    chk("lu_stall1", {31'b0, stall_out}, 32'h1);
    tick();
    chk("lu_bub_valid", {31'b0, valid_out}, 32'h0);
    chk("lu_bub_insn", insn_out, 32'h0);
    chk("lu_bub_pc", pc_out, 32'h80020100);
    chk("lu_stall2", {31'b0, stall_out}, 32'h0);
    tick();
    chk("lu_cap_valid", {31'b0, valid_out}, 32'h1);
    chk("lu_cap_insn", insn_out, 32'h00441820);
    chk("lu_cap_pc", pc_out, 32'h80020104);

    // Load into $0 never stalls
    load_word(32'h8C200000, 32'h80020200);
    drive(32'h00441820, 32'h80020204, 1'b1);
    #1;
    chk("lz_stall", {31'b0, stall_out}, 32'h0);
    tick();
    chk("lz_insn", insn_out, 32'h00441820);

    // Jump after load reads no register
    load_word(32'h8C220000, 32'h80020300);
    drive(32'h08000004, 32'h80020304, 1'b1);
    #1;
    chk("lj_stall", {31'b0, stall_out}, 32'h0);
    tick();
    chk("lj_insn", insn_out, 32'h08000004);

    // Store data register depends on the load
    load_word(32'h8C220000, 32'h80020400);
    drive(32'hACA20004, 32'h80020404, 1'b1);
    #1;
    chk("ls_stall", {31'b0, stall_out}, 32'h1);
    tick();
    chk("ls_bub_valid", {31'b0, valid_out}, 32'h0);
    tick();
    chk("ls_cap_insn", insn_out, 32'hACA20004);

    // Back-to-back dependent loads: lw $2; lw $3,0($2) -> bubble, then second load becomes source
    load_word(32'h8C220000, 32'h80020500);
    drive(32'h8C430000, 32'h80020504, 1'b1);
    #1;
    chk("ll_stall1", {31'b0, stall_out}, 32'h1);
    tick();
    tick();
    chk("ll_cap_insn", insn_out, 32'h8C430000);
    drive(32'h00601020, 32'h80020508, 1'b1);
    #1;
    chk("ll_stall2", {31'b0, stall_out}, 32'h1);
    tick();
    chk("ll_bub_valid", {31'b0, valid_out}, 32'h0);

    // Flush beats stall_in
    load_word(32'h00221820, 32'h80020600);
    flush = 1'b1;
    stall_in = 1'b1;
    drive(32'h2001FFFF, 32'h80020604, 1'b1);
    #1;
    chk("fl_stall", {31'b0, stall_out}, 32'h0);
    tick();
    chk("fl_valid", {31'b0, valid_out}, 32'h0);
    chk("fl_insn", insn_out, 32'h0);
    chk("fl_pc", pc_out, 32'h80020600);
    flush = 1'b0;
    stall_in = 1'b0;

    // stall_in held three cycles keeps everything frozen
    load_word(32'h3421FFFF, 32'h80020700);
    snap_insn = insn_out;
    snap_pc = pc_out;
    stall_in = 1'b1;
    drive(32'h0C000010, 32'h80020704, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st%0d_stall", k), {31'b0, stall_out}, 32'h1);
      tick();
      chk($sformatf("st%0d_insn", k), insn_out, snap_insn);
      chk($sformatf("st%0d_pc", k), pc_out, snap_pc);
      chk($sformatf("st%0d_valid", k), {31'b0, valid_out}, 32'h1);
    end
    stall_in = 1'b0;
    #1;
    tick();
    chk("st_rel_insn", insn_out, 32'h0C000010);

    // stall_in over a hazard holds the load; hazard reappears once stall_in drops
    load_word(32'h8C220000, 32'h80020800);
    stall_in = 1'b1;
    drive(32'h00441820, 32'h80020804, 1'b1);
    tick();
    chk("sh_hold_insn", insn_out, 32'h8C220000);
    stall_in = 1'b0;
    #1;
    chk("sh_stall", {31'b0, stall_out}, 32'h1);
    tick();
    chk("sh_bub_valid", {31'b0, valid_out}, 32'h0);

    // Async reset asserted in the cycle that would bubble
    load_word(32'h8C220000, 32'h80020900);
    drive(32'h00441820, 32'h80020904, 1'b1);
    #1;
    chk("ar_pre_stall", {31'b0, stall_out}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, valid_out}, 32'h0);
    chk("ar_pc", pc_out, 32'h80020000);
    chk("ar_insn", insn_out, 32'h0);
    chk("ar_stall", {31'b0, stall_out}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("ar_after_insn", insn_out, 32'h00441820);
    chk("ar_after_valid", {31'b0, valid_out}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
